// File: rtl/scalar_wb_pkg.sv
// Shared widths, write-entry type and one-hot helper for the scalar writeback path.
// No logic of its own; no latency, no backpressure.
package scalar_wb_pkg;

   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;
   localparam int ADDR_W   = $clog2(NUM_REGS);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
      reg_onehot    = '0;
      reg_onehot[a] = 1'b1;
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of writeback entries; head is visible combinationally, pop takes effect at posedge.
// Push is ignored when full and pop is ignored when empty; the caller gates on full/empty.
module wb_result_fifo
   import scalar_wb_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  wb_entry_t        push_data,
   input  logic             pop,
   output wb_entry_t        head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/scalar_writeback_unit.sv
// Merges ALU and queued load results onto the scalar bank write port; ALU issues 1 cycle later, loads >=2.
// ALU has absolute priority and no backpressure; loads stall on ld_ready when the queue is full.
module scalar_writeback_unit
   import scalar_wb_pkg::*;
#(
   parameter int LQ_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alu_valid,
   input  logic [ADDR_W-1:0]   alu_addr,
   input  logic [DATA_W-1:0]   alu_data,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0]   ld_data,
   input  logic                rsv_valid,
   input  logic [ADDR_W-1:0]   rsv_addr,
   output logic [NUM_REGS-1:0] pending,
   output logic                wEn_SR,
   output logic [ADDR_W-1:0]   regsAddr3,
   output logic [DATA_W-1:0]   regsWriteData
);

   localparam int CNT_W = $clog2(LQ_DEPTH + 1);

   wb_entry_t           lq_head;
   wb_entry_t           issue_entry;
   logic                lq_full;
   logic                lq_empty;
   logic [CNT_W-1:0]    lq_count;
   logic                lq_push;
   logic                lq_pop;
   logic                issue;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;

   // Readiness ignores a same-cycle pop so the handshake never depends on alu_valid.
   assign ld_ready = (lq_count != CNT_W'(LQ_DEPTH));
   assign lq_push  = ld_valid && !lq_full;

   wb_result_fifo #(.DEPTH(LQ_DEPTH)) u_ld_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (lq_push),
      .push_data ({ld_addr, ld_data}),
      .pop       (lq_pop),
      .head      (lq_head),
      .full      (lq_full),
      .empty     (lq_empty),
      .count     (lq_count)
   );

   always_comb begin
      issue       = 1'b0;
      lq_pop      = 1'b0;
      issue_entry = lq_head;
      clr_mask    = '0;
      set_mask    = '0;
      if (alu_valid) begin
         issue       = 1'b1;
         issue_entry = '{addr: alu_addr, data: alu_data};
      end else if (!lq_empty) begin
         issue  = 1'b1;
         lq_pop = 1'b1;
      end
      if (issue)     clr_mask = reg_onehot(issue_entry.addr);
      if (rsv_valid) set_mask = reg_onehot(rsv_addr);
   end

   // A reservation landing on the register being written wins: it belongs to a younger instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wEn_SR        <= 1'b0;
         regsAddr3     <= '0;
         regsWriteData <= '0;
         pending       <= '0;
      end else begin
         wEn_SR  <= issue;
         pending <= (pending & ~clr_mask) | set_mask;
         if (issue) begin
            regsAddr3     <= issue_entry.addr;
            regsWriteData <= issue_entry.data;
         end
      end
   end

endmodule
